// File: rtl/pe_pipe_param.sv
// -----------------------------------------------------------------------------
// pe_pipe_param
// Two-stage pipelined priority encoder. Reports the index of the highest set
// bit of an accepted request vector, using a valid/ready handshake on both
// sides with full-throughput stall handling.
//
// Stage 1 splits d into ROWS rows of ROW_W bits and registers, per row, an
// OR flag and the local index of that row's highest set bit. Stage 2 selects
// the highest-numbered flagged row and concatenates {row, local index}.
//
// Parameters
//   WIDTH : request vector width, power of two, 64..1024
//   ROW_W : row width, power of two (>= 2), divides WIDTH
//
// Ports
//   clk       : clock, all state on rising edge
//   rst_n     : asynchronous active-low reset
//   d         : request vector, sampled only on a transfer in
//   in_valid  : d is presented
//   in_ready  : block accepts d this cycle (independent of in_valid)
//   q         : index of highest set bit of the accepted d (0 when d == 0)
//   v         : accepted d had at least one bit set
//   out_valid : q/v (and multi) hold a result
//   out_ready : consumer takes the result this cycle
//   multi     : accepted d had two or more bits set (PE_MULTI_HIT_EN only)
//
// Configuration macro
//   PE_MULTI_HIT_EN : when defined, adds the multi port and its logic.
// -----------------------------------------------------------------------------
module pe_pipe_param #(
  parameter int WIDTH = 256,
  parameter int ROW_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         d,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [$clog2(WIDTH)-1:0] q,
  output logic                     v,
  output logic                     out_valid,
`ifdef PE_MULTI_HIT_EN
  output logic                     multi,
`endif
  input  logic                     out_ready
);

  localparam int QW   = $clog2(WIDTH);
  localparam int ROWS = WIDTH / ROW_W;
  localparam int LW   = $clog2(ROW_W);

  // Stage 1 combinational row summaries and registers
  logic [ROWS-1:0] row_flag_s;
  logic [LW-1:0]   row_idx_s [ROWS];
  logic            s1_valid_r;
  logic [ROWS-1:0] row_flag_r;
  logic [LW-1:0]   row_idx_r [ROWS];

  // Stage 2 combinational selection and output registers
  logic [QW-1:0]   q_s;
  logic            v_s;
  logic            out_valid_r;
  logic [QW-1:0]   q_r;
  logic            v_r;

  // Handshake: a stage may load whenever its successor frees up
  logic            s2_adv_s;
  logic            s1_adv_s;

`ifdef PE_MULTI_HIT_EN
  logic [ROWS-1:0] row_multi_s;
  logic [ROWS-1:0] row_multi_r;
  logic            multi_s;
  logic            multi_r;
`endif

  assign s2_adv_s = !out_valid_r || out_ready;
  assign s1_adv_s = !s1_valid_r || s2_adv_s;
  assign in_ready = s1_adv_s;

  // Per-row OR flag and highest-set local index (ascending scan, last hit wins)
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      row_flag_s[r] = 1'b0;
      row_idx_s[r]  = '0;
`ifdef PE_MULTI_HIT_EN
      row_multi_s[r] = 1'b0;
`endif
      for (int i = 0; i < ROW_W; i++) begin
        if (d[r*ROW_W + i]) begin
`ifdef PE_MULTI_HIT_EN
          // A second hit in the same row means the row is multi-hit
          row_multi_s[r] = row_multi_s[r] | row_flag_s[r];
`endif
          row_flag_s[r] = 1'b1;
          row_idx_s[r]  = LW'(i);
        end else begin
          row_idx_s[r]  = row_idx_s[r];
        end
      end
    end
  end

  // Stage 1 registers: load a new row summary whenever stage 1 advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      row_flag_r <= '0;
      for (int r = 0; r < ROWS; r++) begin
        row_idx_r[r] <= '0;
      end
`ifdef PE_MULTI_HIT_EN
      row_multi_r <= '0;
`endif
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        row_flag_r <= row_flag_s;
        for (int r = 0; r < ROWS; r++) begin
          row_idx_r[r] <= row_idx_s[r];
        end
`ifdef PE_MULTI_HIT_EN
        row_multi_r <= row_multi_s;
`endif
      end
    end
  end

  // Highest flagged row wins; an all-zero vector yields q = 0, v = 0
  always_comb begin
    q_s = '0;
    v_s = 1'b0;
`ifdef PE_MULTI_HIT_EN
    multi_s = 1'b0;
`endif
    for (int r = 0; r < ROWS; r++) begin
      if (row_flag_r[r]) begin
`ifdef PE_MULTI_HIT_EN
        // Multi if this row is multi-hit or an earlier row was also flagged
        multi_s = multi_s | v_s | row_multi_r[r];
`endif
        v_s = 1'b1;
        q_s = QW'(r * ROW_W) | QW'(row_idx_r[r]);
      end else begin
        q_s = q_s;
      end
    end
  end

  // Stage 2 output registers: hold while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      q_r         <= '0;
      v_r         <= 1'b0;
`ifdef PE_MULTI_HIT_EN
      multi_r     <= 1'b0;
`endif
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        q_r     <= q_s;
        v_r     <= v_s;
`ifdef PE_MULTI_HIT_EN
        multi_r <= multi_s;
`endif
      end
    end
  end

  assign out_valid = out_valid_r;
  assign q         = q_r;
  assign v         = v_r;
`ifdef PE_MULTI_HIT_EN
  assign multi     = multi_r;
`endif

endmodule

// File: tb/tb_pe_pipe_param.sv
// -----------------------------------------------------------------------------
// tb_pe_pipe_param
// Directed self-checking bench for pe_pipe_param at WIDTH=256, ROW_W=64.
// Inputs are driven just after the falling edge, outputs sampled there too.
// Build with +define+PE_MULTI_HIT_EN to also exercise the multi output.
// -----------------------------------------------------------------------------
module tb_pe_pipe_param;

  localparam int WIDTH = 256;
  localparam int ROW_W = 64;
  localparam int QW    = 8;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] d;
  logic             in_valid;
  logic             in_ready;
  logic [QW-1:0]    q;
  logic             v;
  logic             out_valid;
  logic             out_ready;
`ifdef PE_MULTI_HIT_EN
  logic             multi;
`endif

  int checks = 0;
  int errors = 0;

  pe_pipe_param #(.WIDTH(WIDTH), .ROW_W(ROW_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q         (q),
    .v         (v),
    .out_valid (out_valid),
`ifdef PE_MULTI_HIT_EN
    .multi     (multi),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] onehot(input int b);
    logic [WIDTH-1:0] x;
    x = '0;
    x[b] = 1'b1;
    return x;
  endfunction

  // Reference: flat scan from the top, independent of any row split
  function automatic int highest(input logic [WIDTH-1:0] x);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (x[i]) return i;
    end
    return -1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; d = '1;
    #3;
    checks++;
    if ({out_valid, v, q, in_ready} !== {1'b0, 1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset: ov/v/q/ir got %b/%b/%0d/%b want 0/0/0/1", out_valid, v, q, in_ready);
    end
`ifdef PE_MULTI_HIT_EN
    checks++;
    if (multi !== 1'b0) begin errors++; $display("FAIL reset_multi: got %b want 0", multi); end
`endif
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_zero();
    @(negedge clk);
    d = '0; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0; d = '1;
    @(negedge clk);
    checks++;
    if ({out_valid, v, q} !== {1'b1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL zero_result: ov/v/q got %b/%b/%0d want 1/0/0", out_valid, v, q);
    end
`ifdef PE_MULTI_HIT_EN
    checks++;
    if (multi !== 1'b0) begin errors++; $display("FAIL zero_multi: got %b want 0", multi); end
`endif
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_drain: out_valid got %b want 0", out_valid); end
  endtask

  // Bit k is offered at cycle k; its result is visible two falling edges later
  task automatic test_sweep();
    out_ready = 1'b1;
    for (int k = 0; k < WIDTH + 2; k++) begin
      @(negedge clk);
      if (k < WIDTH) begin
        d = onehot(k); in_valid = 1'b1;
      end else begin
        d = '0; in_valid = 1'b0;
      end
      #1;
      if (k < WIDTH) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL sweep_in_ready k=%0d: got %b want 1", k, in_ready); end
      end
      if (k >= 2) begin
        checks++;
        if ({out_valid, v, q} !== {1'b1, 1'b1, 8'(k - 2)}) begin
          errors++;
          $display("FAIL sweep bit=%0d: ov/v/q got %b/%b/%0d want 1/1/%0d", k - 2, out_valid, v, q, k - 2);
        end
`ifdef PE_MULTI_HIT_EN
        checks++;
        if (multi !== 1'b0) begin errors++; $display("FAIL sweep_multi bit=%0d: got %b want 0", k - 2, multi); end
`endif
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_multi_hit();
    out_ready = 1'b1;
    @(negedge clk);
    d = onehot(5) | onehot(123) | onehot(200); in_valid = 1'b1;
    @(negedge clk);
    d = onehot(63) | onehot(64);
    @(negedge clk);
    in_valid = 1'b0; d = '0;
    checks++;
    if ({out_valid, v, q} !== {1'b1, 1'b1, 8'd200}) begin
      errors++; $display("FAIL multi_a: ov/v/q got %b/%b/%0d want 1/1/200", out_valid, v, q);
    end
`ifdef PE_MULTI_HIT_EN
    checks++;
    if (multi !== 1'b1) begin errors++; $display("FAIL multi_a_flag: got %b want 1", multi); end
`endif
    @(negedge clk);
    checks++;
    if ({out_valid, v, q} !== {1'b1, 1'b1, 8'd64}) begin
      errors++; $display("FAIL multi_b: ov/v/q got %b/%b/%0d want 1/1/64", out_valid, v, q);
    end
`ifdef PE_MULTI_HIT_EN
    checks++;
    if (multi !== 1'b1) begin errors++; $display("FAIL multi_b_flag: got %b want 1", multi); end
`endif
    // Two bits within one row must also count as multi
    @(negedge clk);
    d = onehot(130) | onehot(131); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, v, q} !== {1'b1, 1'b1, 8'd131}) begin
      errors++; $display("FAIL multi_c: ov/v/q got %b/%b/%0d want 1/1/131", out_valid, v, q);
    end
`ifdef PE_MULTI_HIT_EN
    checks++;
    if (multi !== 1'b1) begin errors++; $display("FAIL multi_c_flag: got %b want 1", multi); end
`endif
    @(negedge clk);
  endtask

  task automatic test_stall();
    @(negedge clk);
    out_ready = 1'b0; d = onehot(10); in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ir0: got %b want 1", in_ready); end
    @(negedge clk);
    d = onehot(20);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_ir1: got %b want 1", in_ready); end
    @(negedge clk);
    d = onehot(30);
    for (int c = 2; c < 5; c++) begin
      #1;
      checks++;
      if ({in_ready, out_valid, v, q} !== {1'b0, 1'b1, 1'b1, 8'd10}) begin
        errors++;
        $display("FAIL stall_hold c=%0d: ir/ov/v/q got %b/%b/%b/%0d want 0/1/1/10", c, in_ready, out_valid, v, q);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid, q} !== {1'b1, 1'b1, 8'd10}) begin
      errors++; $display("FAIL stall_release: ir/ov/q got %b/%b/%0d want 1/1/10", in_ready, out_valid, q);
    end
    @(negedge clk);
    in_valid = 1'b0; d = '0;
    checks++;
    if ({out_valid, q} !== {1'b1, 8'd20}) begin
      errors++; $display("FAIL stall_second: ov/q got %b/%0d want 1/20", out_valid, q);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, q} !== {1'b1, 8'd30}) begin
      errors++; $display("FAIL stall_third: ov/q got %b/%0d want 1/30", out_valid, q);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    @(negedge clk);
    d = onehot(7); in_valid = 1'b1;
    @(negedge clk);
    d = onehot(8);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if ({out_valid, q} !== {1'b1, 8'd7}) begin
      errors++; $display("FAIL midrst_pre: ov/q got %b/%0d want 1/7", out_valid, q);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, v, q, in_ready} !== {1'b0, 1'b0, 8'd0, 1'b1}) begin
      errors++;
      $display("FAIL midrst_async: ov/v/q/ir got %b/%b/%0d/%b want 0/0/0/1", out_valid, v, q, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale c=%0d: out_valid got %b want 0", c, out_valid); end
    end
  endtask

  function automatic logic [WIDTH-1:0] gen_vec(input int idx);
    logic [WIDTH-1:0] a, b, c;
    for (int w = 0; w < WIDTH / 32; w++) begin
      a[w*32 +: 32] = $urandom;
      b[w*32 +: 32] = $urandom;
      c[w*32 +: 32] = $urandom;
    end
    case (idx % 4)
      0: return a;
      1: return onehot($urandom_range(0, WIDTH - 1));
      2: return a & b & c;
      default: return (idx == 3) ? '0 : ((a & b) >> $urandom_range(64, 250));
    endcase
  endfunction

  task automatic test_random();
    logic [QW-1:0]    exp_q [$];
    logic             exp_v [$];
    logic             exp_m [$];
    logic [WIDTH-1:0] vec;
    int               sent, got, cyc, hb;
    sent = 0; got = 0; cyc = 0;
    vec = gen_vec(0);
    while (got < 20 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      out_ready = ($urandom_range(0, 2) != 0);
      in_valid  = (sent < 20);
      d         = vec;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_spurious: q=%0d with nothing outstanding", q);
        end else begin
          if ({v, q} !== {exp_v[0], exp_q[0]}) begin
            errors++;
            $display("FAIL rand_result #%0d: v/q got %b/%0d want %b/%0d", got, v, q, exp_v[0], exp_q[0]);
          end
`ifdef PE_MULTI_HIT_EN
          checks++;
          if (multi !== exp_m[0]) begin errors++; $display("FAIL rand_multi #%0d: got %b want %b", got, multi, exp_m[0]); end
`endif
          void'(exp_q.pop_front()); void'(exp_v.pop_front()); void'(exp_m.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        hb = highest(vec);
        exp_q.push_back((hb < 0) ? 8'd0 : 8'(hb));
        exp_v.push_back(hb >= 0);
        exp_m.push_back($countones(vec) >= 2);
        sent++;
        vec = gen_vec(sent);
      end
    end
    checks++;
    if (got < 20) begin
      errors++; $display("FAIL rand_timeout: got %0d results want 20", got);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_sweep();
    test_multi_hit();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
